// File: rtl/uart_tx_arb.sv
// Round-robin arbiter that shares one UART byte transmitter among N_REQ sources.
// It grants one requester, latches its byte, starts the transmitter and waits for done plus an optional guard gap.
module uart_tx_arb #(
    parameter  int N_REQ   = 4,
    parameter  int GAP_CYC = 0,
    localparam int SW      = $clog2(N_REQ)
) (
    input  logic               I_CLK,
    input  logic               I_RSTF,
    input  logic [N_REQ-1:0]   I_REQ,
    input  logic [8*N_REQ-1:0] I_DATA,
    output logic [N_REQ-1:0]   O_GNT,
    output logic               O_TX_START,
    output logic [7:0]         O_TX_DATA,
    input  logic               I_TX_DONE,
    output logic [SW-1:0]      O_SRC,
    output logic               O_DONE,
    output logic               O_BUSY
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        GAP
    } state_e;

    state_e             state_q, state_d;
    logic [SW-1:0]      ptr_q, ptr_d;
    logic [7:0]         gap_q, gap_d;
    logic [N_REQ-1:0]   gnt_q, gnt_d;
    logic               start_q, start_d;
    logic [7:0]         data_q, data_d;
    logic [SW-1:0]      src_q, src_d;
    logic               done_q, done_d;

    logic               found;
    logic [SW-1:0]      win;

    // Winner is the first set request scanning upward from ptr with wraparound.
    always_comb begin
        int j;
        found = 1'b0;
        win   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            j = int'(ptr_q) + k;
            if (j >= N_REQ) j = j - N_REQ;
            if (!found && I_REQ[SW'(j)]) begin
                found = 1'b1;
                win   = SW'(j);
            end
        end
    end

    // NOTE: every signal gets a default before the case so no path can leave it unassigned (no latches).
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gap_d   = gap_q;
        gnt_d   = '0;
        start_d = 1'b0;
        data_d  = data_q;
        src_d   = src_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    data_d       = I_DATA[{win, 3'b000} +: 8];
                    src_d        = win;
                    gnt_d[win]   = 1'b1;
                    start_d      = 1'b1;
                    ptr_d        = (win == SW'(N_REQ - 1)) ? '0 : win + SW'(1);
                    state_d      = WAIT;
                end
            end
            WAIT: begin
                // A done coinciding with our own start pulse cannot belong to this frame.
                if (I_TX_DONE && !start_q) begin
                    done_d = 1'b1;
                    if (GAP_CYC == 0) begin
                        state_d = IDLE;
                    end else begin
                        gap_d   = 8'(GAP_CYC - 1);
                        state_d = GAP;
                    end
                end
            end
            GAP: begin
                if (gap_q == 8'd0) state_d = IDLE;
                else               gap_d   = gap_q - 8'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update from the same pre-edge values.
    always_ff @(posedge I_CLK) begin
        if (!I_RSTF) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            gap_q   <= 8'd0;
            gnt_q   <= '0;
            start_q <= 1'b0;
            data_q  <= 8'h00;
            src_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gap_q   <= gap_d;
            gnt_q   <= gnt_d;
            start_q <= start_d;
            data_q  <= data_d;
            src_q   <= src_d;
            done_q  <= done_d;
        end
    end

    assign O_GNT      = gnt_q;
    assign O_TX_START = start_q;
    assign O_TX_DATA  = data_q;
    assign O_SRC      = src_q;
    assign O_DONE     = done_q;
    assign O_BUSY     = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_arb.sv
// Self-checking bench for uart_tx_arb: one instance without guard gap, one with GAP_CYC = 5.
// Expected grants come from a rotating-scan model of the round-robin rule.
module tb_uart_tx_arb;

    localparam int N = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          sel = 1'b0;
    logic [N-1:0]  req = '0;
    logic [8*N-1:0] data = '0;
    logic          tx_done = 1'b0;

    logic [N-1:0]  req0, req5, gnt0, gnt5, gnt;
    logic          done_in0, done_in5;
    logic          start0, start5, start;
    logic [7:0]    txd0, txd5, tx_data;
    logic [1:0]    src0, src5, src;
    logic          odone0, odone5, done;
    logic          busy0, busy5, busy;

    int errors = 0;
    int checks = 0;
    int mptr[2];

    always #5 clk = ~clk;

    assign req0     = sel ? '0 : req;
    assign req5     = sel ? req : '0;
    assign done_in0 = sel ? 1'b0 : tx_done;
    assign done_in5 = sel ? tx_done : 1'b0;
    assign gnt      = sel ? gnt5 : gnt0;
    assign start    = sel ? start5 : start0;
    assign tx_data  = sel ? txd5 : txd0;
    assign src      = sel ? src5 : src0;
    assign done     = sel ? odone5 : odone0;
    assign busy     = sel ? busy5 : busy0;

    uart_tx_arb #(.N_REQ(N), .GAP_CYC(0)) dut0 (
        .I_CLK(clk), .I_RSTF(rst_n), .I_REQ(req0), .I_DATA(data),
        .O_GNT(gnt0), .O_TX_START(start0), .O_TX_DATA(txd0), .I_TX_DONE(done_in0),
        .O_SRC(src0), .O_DONE(odone0), .O_BUSY(busy0)
    );

    uart_tx_arb #(.N_REQ(N), .GAP_CYC(5)) dut5 (
        .I_CLK(clk), .I_RSTF(rst_n), .I_REQ(req5), .I_DATA(data),
        .O_GNT(gnt5), .O_TX_START(start5), .O_TX_DATA(txd5), .I_TX_DONE(done_in5),
        .O_SRC(src5), .O_DONE(odone5), .O_BUSY(busy5)
    );

    // Reference: first requester found walking p, p+1, ... modulo N.
    function automatic int pick(int p, logic [N-1:0] m);
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (p + k) % N;
            if (((m >> idx) & 4'd1) != 4'd0) return idx;
        end
        return -1;
    endfunction

    function automatic logic [7:0] byte_of(logic [8*N-1:0] d, int i);
        return 8'(d >> (8 * i));
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_start(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!start && n < 64);
        checks++;
        if (!start) begin
            errors++;
            $display("FAIL wait_start: no O_TX_START within %0d cycles", n);
        end
    endtask

    task automatic test_reset();
        sel = 1'b0;
        rst_n = 1'b0;
        req = 4'b1111;
        data = $urandom;
        repeat (3) begin
            step();
            checks++;
            if ({gnt, start, tx_data, src, done, busy} !== '0) begin
                errors++;
                $display("FAIL reset_outputs: gnt=%b start=%b data=%h src=%0d done=%b busy=%b, required all zero",
                         gnt, start, tx_data, src, done, busy);
            end
        end
        rst_n = 1'b1;
        mptr[0] = 0;
        mptr[1] = 0;
        step();
        checks++;
        if (gnt !== 4'b0001 || start !== 1'b1 || src !== 2'd0 || tx_data !== byte_of(data, 0) || busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_first_grant: gnt=%b start=%b src=%0d data=%h busy=%b, required 0001 1 0 %h 1",
                     gnt, start, src, tx_data, busy, byte_of(data, 0));
        end
        mptr[0] = 1;
        req = '0;
        step();
        checks++;
        if (gnt !== 4'b0000 || start !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_pulse_width: gnt=%b start=%b busy=%b, required 0000 0 1", gnt, start, busy);
        end
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_frame_done: done=%b busy=%b, required 1 0", done, busy);
        end
    endtask

    task automatic test_single();
        bit bad;
        sel = 1'b0;
        req = 4'b0100;
        data = $urandom;
        data[23:16] = 8'hA5;
        step();
        checks++;
        if (start !== 1'b1 || tx_data !== 8'hA5 || src !== 2'd2 || gnt !== 4'b0100) begin
            errors++;
            $display("FAIL single_start: start=%b data=%h src=%0d gnt=%b, required 1 a5 2 0100", start, tx_data, src, gnt);
        end
        mptr[0] = 3;
        req = '0;
        data[23:16] = 8'h00;
        bad = 1'b0;
        repeat (199) begin
            step();
            if (done !== 1'b0 || busy !== 1'b1 || start !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL single_wait: early done/start or busy dropped while waiting, required busy held");
        end
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || tx_data !== 8'hA5) begin
            errors++;
            $display("FAIL single_done: done=%b busy=%b data=%h, required 1 0 a5", done, busy, tx_data);
        end
        step();
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL single_done_pulse: done=%b, required 0", done);
        end
    endtask

    task automatic run_frames(input int frames, input logic [N-1:0] mask, input string name);
        int n, w;
        logic [7:0] exp_byte;
        for (int f = 0; f < frames; f++) begin
            req = mask;
            wait_start(n);
            w = pick(mptr[0], mask);
            exp_byte = byte_of(data, w);
            checks++;
            if (gnt !== 4'(1 << w) || src !== 2'(w) || tx_data !== exp_byte) begin
                errors++;
                $display("FAIL %s[%0d]: gnt=%b src=%0d data=%h, required gnt=%b src=%0d data=%h",
                         name, f, gnt, src, tx_data, 4'(1 << w), w, exp_byte);
            end
            if (f > 0) begin
                checks++;
                if (n !== 1) begin
                    errors++;
                    $display("FAIL %s_latency[%0d]: start %0d cycles after done, required 1", name, f, n);
                end
            end
            mptr[0] = (w + 1) % N;
            data = $urandom;
            repeat (10) step();
            tx_done = 1'b1;
            step();
            tx_done = 1'b0;
            checks++;
            if (done !== 1'b1 || tx_data !== exp_byte) begin
                errors++;
                $display("FAIL %s_done[%0d]: done=%b data=%h, required 1 %h", name, f, done, tx_data, exp_byte);
            end
        end
    endtask

    task automatic test_fairness();
        sel = 1'b0;
        rst_n = 1'b0;
        req = '0;
        step();
        rst_n = 1'b1;
        mptr[0] = 0;
        mptr[1] = 0;
        data = $urandom;
        run_frames(8, 4'b1111, "fair_all");
        run_frames(4, 4'b1101, "fair_skip1");
        req = '0;
        step();
    endtask

    task automatic test_random();
        int n, w, dly;
        logic [N-1:0] mask;
        logic [7:0] exp_byte;
        sel = 1'b0;
        for (int f = 0; f < 20; f++) begin
            mask = 4'($urandom_range(1, 15));
            req = mask;
            data = $urandom;
            wait_start(n);
            w = pick(mptr[0], mask);
            exp_byte = byte_of(data, w);
            checks++;
            if (gnt !== 4'(1 << w) || src !== 2'(w) || tx_data !== exp_byte || busy !== 1'b1) begin
                errors++;
                $display("FAIL random[%0d] mask=%b: gnt=%b src=%0d data=%h, required gnt=%b src=%0d data=%h",
                         f, mask, gnt, src, tx_data, 4'(1 << w), w, exp_byte);
            end
            mptr[0] = (w + 1) % N;
            req = 4'($urandom_range(0, 15));
            data = $urandom;
            dly = $urandom_range(1, 8);
            repeat (dly) step();
            tx_done = 1'b1;
            step();
            tx_done = 1'b0;
            checks++;
            if (done !== 1'b1 || busy !== 1'b0 || tx_data !== exp_byte || src !== 2'(w)) begin
                errors++;
                $display("FAIL random_done[%0d]: done=%b busy=%b data=%h src=%0d, required 1 0 %h %0d",
                         f, done, busy, tx_data, src, exp_byte, w);
            end
        end
        req = '0;
        step();
    endtask

    task automatic test_spurious();
        int w;
        sel = 1'b0;
        req = '0;
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL spurious_idle: done=%b busy=%b, required 0 0", done, busy);
        end
        req = 4'b1000;
        step();
        w = pick(mptr[0], 4'b1000);
        checks++;
        if (start !== 1'b1 || gnt !== 4'(1 << w)) begin
            errors++;
            $display("FAIL spurious_grant: start=%b gnt=%b, required 1 %b", start, gnt, 4'(1 << w));
        end
        mptr[0] = (w + 1) % N;
        req = '0;
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        checks++;
        if (done !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL spurious_start_cycle: done=%b busy=%b, required 0 1", done, busy);
        end
        repeat (3) step();
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL spurious_real_done: done=%b busy=%b, required 1 0", done, busy);
        end
    endtask

    task automatic test_gap();
        int n, w;
        bit spur, bad_busy;
        sel = 1'b1;
        req = 4'b0011;
        data = $urandom;
        step();
        w = pick(mptr[1], 4'b0011);
        checks++;
        if (start !== 1'b1 || gnt !== 4'(1 << w)) begin
            errors++;
            $display("FAIL gap_first: start=%b gnt=%b, required 1 %b", start, gnt, 4'(1 << w));
        end
        mptr[1] = (w + 1) % N;
        req = 4'b0010;
        repeat (3) step();
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        n = 1;
        checks++;
        if (done !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL gap_done: done=%b busy=%b, required 1 1", done, busy);
        end
        spur = 1'b0;
        bad_busy = 1'b0;
        while (!start && n < 20) begin
            if (n == 2) tx_done = 1'b1;
            step();
            tx_done = 1'b0;
            n++;
            if (done) spur = 1'b1;
            if (n <= 5 && !busy) bad_busy = 1'b1;
            if (n == 6 && busy) bad_busy = 1'b1;
        end
        checks++;
        if (n !== 7) begin
            errors++;
            $display("FAIL gap_spacing: next start %0d cycles after done, required 7", n);
        end
        checks++;
        if (spur || bad_busy) begin
            errors++;
            $display("FAIL gap_state: spurious_done=%b busy_wrong=%b, required 0 0", spur, bad_busy);
        end
        w = pick(mptr[1], 4'b0010);
        checks++;
        if (gnt !== 4'(1 << w) || src !== 2'(w)) begin
            errors++;
            $display("FAIL gap_second: gnt=%b src=%0d, required %b %0d", gnt, src, 4'(1 << w), w);
        end
        mptr[1] = (w + 1) % N;
        req = '0;
        repeat (2) step();
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        repeat (8) step();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL gap_return_idle: busy=%b, required 0", busy);
        end
    endtask

    task automatic test_reset_mid();
        int w;
        sel = 1'b0;
        req = 4'b0100;
        data = $urandom;
        step();
        checks++;
        if (start !== 1'b1) begin
            errors++;
            $display("FAIL midreset_start: start=%b, required 1", start);
        end
        req = '0;
        repeat (4) step();
        rst_n = 1'b0;
        step();
        checks++;
        if (busy !== 1'b0 || gnt !== 4'b0000 || tx_data !== 8'h00 || src !== 2'd0) begin
            errors++;
            $display("FAIL midreset_state: busy=%b gnt=%b data=%h src=%0d, required 0 0000 00 0", busy, gnt, tx_data, src);
        end
        rst_n = 1'b1;
        mptr[0] = 0;
        mptr[1] = 0;
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midreset_late_done: done=%b busy=%b, required 0 0", done, busy);
        end
        req = 4'b1010;
        step();
        w = pick(mptr[0], 4'b1010);
        checks++;
        if (start !== 1'b1 || gnt !== 4'(1 << w)) begin
            errors++;
            $display("FAIL midreset_ptr: start=%b gnt=%b, required 1 %b", start, gnt, 4'(1 << w));
        end
        req = '0;
        repeat (2) step();
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_random();
        test_spurious();
        test_gap();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
